// File: rtl/mac_accumulator_s2.sv
// mac_accumulator_s2: multiply-accumulate stage behind the stage-2 control FSM.
// Tags each address, multiplies the returned operands and emits one sum per pass.
module mac_accumulator_s2 #(
    parameter int DATA_W  = 8,
    parameter int N_TERMS = 36,
    parameter int ACC_W   = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     busy_proc,
    input  logic [1:0]               dir,
    input  logic [5:0]               dir_counter,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [ACC_W-1:0]         result_data,
    output logic                     result_valid,
    output logic [1:0]               result_dir,
    output logic                     frame_done,
    output logic                     seq_err,
    output logic                     acc_busy
);

    localparam int PW = 2 * DATA_W;
    localparam logic [5:0] LAST_IDX = 6'(N_TERMS - 1);
    localparam logic [5:0] N_CNT    = 6'(N_TERMS);

    // stage T tag
    logic       t_v;
    logic [1:0] t_dir;
    logic       t_first;
    logic       t_last;

    // stage P tag and product
    logic             p_v;
    logic [1:0]       p_dir;
    logic             p_first;
    logic             p_last;
    logic [ACC_W-1:0] p_prod;

    // stage A state
    logic [ACC_W-1:0] acc;
    logic [5:0]       cnt;
    logic             pass_open;

    logic signed [PW-1:0] mul;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     acc_next;
    logic [5:0]           cnt_next;
    logic                 err_now;

    assign mul      = a_data * w_data;
    assign prod_ext = {{(ACC_W - PW){mul[PW-1]}}, mul};
    assign acc_next = p_first ? p_prod : acc + p_prod;
    assign cnt_next = p_first ? 6'd1 : cnt + 6'd1;
    assign err_now  = p_v & ((p_first & pass_open) |
                             (~p_first & ~pass_open) |
                             (p_last & (cnt_next != N_CNT)));
    assign acc_busy = pass_open | t_v | p_v;

    // Capture the address-phase tag while the operands are being read
    always_ff @(posedge clk) begin
        if (reset) begin
            t_v     <= 1'b0;
            t_dir   <= 2'd0;
            t_first <= 1'b0;
            t_last  <= 1'b0;
        end else begin
            t_v     <= busy_proc;
            t_dir   <= dir;
            t_first <= (dir_counter == 6'd0);
            t_last  <= (dir_counter == LAST_IDX);
        end
    end

    // Multiply the returned operands and advance the tag
    always_ff @(posedge clk) begin
        if (reset) begin
            p_v     <= 1'b0;
            p_dir   <= 2'd0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
        end else begin
            p_v     <= t_v;
            p_dir   <= t_dir;
            p_first <= t_first;
            p_last  <= t_last;
            p_prod  <= prod_ext;
        end
    end

    // Accumulate, track the open pass and emit one result per pass
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= 6'd0;
            pass_open    <= 1'b0;
            result_data  <= '0;
            result_valid <= 1'b0;
            result_dir   <= 2'd0;
            frame_done   <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (p_v) begin
                acc <= acc_next;
                cnt <= cnt_next;
                if (p_first) begin
                    pass_open <= 1'b1;
                end
                if (p_last) begin
                    pass_open    <= 1'b0;
                    result_data  <= acc_next;
                    result_dir   <= p_dir;
                    result_valid <= 1'b1;
                    frame_done   <= (p_dir == 2'd3);
                end
            end
            if (err_now) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator_s2.sv
// tb_mac_accumulator_s2: drives FSM-like address streams and a 1-cycle memory,
// and compares per-pass sums against plain-arithmetic expectations.
module tb_mac_accumulator_s2;

    logic              clk = 1'b0;
    logic              reset;
    logic              busy_proc;
    logic [1:0]        dir;
    logic [5:0]        dir_counter;
    logic signed [7:0] a_data;
    logic signed [7:0] w_data;
    logic [21:0]       result_data;
    logic              result_valid;
    logic [1:0]        result_dir;
    logic              frame_done;
    logic              seq_err;
    logic              acc_busy;

    mac_accumulator_s2 dut (
        .clk          (clk),
        .reset        (reset),
        .busy_proc    (busy_proc),
        .dir          (dir),
        .dir_counter  (dir_counter),
        .a_data       (a_data),
        .w_data       (w_data),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_dir   (result_dir),
        .frame_done   (frame_done),
        .seq_err      (seq_err),
        .acc_busy     (acc_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int res_cnt = 0;
    int fd_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // operand memories and pending expectations
    logic signed [7:0] am [4][36];
    logic signed [7:0] wm [4][36];
    logic signed [7:0] nxt_a = 0;
    logic signed [7:0] nxt_w = 0;
    logic [1:0]  q_dir [$];
    logic [21:0] q_sum [$];
    int          q_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [21:0] pass_sum(input int d);
        int s = 0;
        for (int i = 0; i < 36; i++) s += int'(am[d][i]) * int'(wm[d][i]);
        return 22'(s);
    endfunction

    task automatic fill(input int mode);
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 36; i++) begin
                case (mode)
                    0: begin am[d][i] = 1; wm[d][i] = 1; end
                    1: begin am[d][i] = 8'(i); wm[d][i] = 1; end
                    2: begin am[d][i] = 8'(i); wm[d][i] = -1; end
                    3: begin am[d][i] = -128; wm[d][i] = 127; end
                    4: begin am[d][i] = -128; wm[d][i] = -128; end
                    default: begin
                        am[d][i] = 8'($urandom);
                        wm[d][i] = 8'($urandom);
                    end
                endcase
            end
        end
    endtask

    // one address cycle; operands of the previous address appear now
    task automatic step(input logic b, input logic [1:0] d,
                        input logic [5:0] c);
        @(negedge clk);
        busy_proc   = b;
        dir         = d;
        dir_counter = c;
        a_data      = nxt_a;
        w_data      = nxt_w;
        nxt_a = b ? am[d][c] : 8'($urandom);
        nxt_w = b ? wm[d][c] : 8'($urandom);
        if (b && c == 6'd35) begin
            q_dir.push_back(d);
            q_sum.push_back(pass_sum(d));
            q_cyc.push_back(cyc + 3);
        end
    endtask

    task automatic run_frame();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 36; c++) step(1'b1, 2'(d), 6'(c));
            if (d == 0) chk("acc_busy_mid", 32'(acc_busy), 32'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 6'd0);
        chk("pending_results", q_sum.size(), 0);
        chk("acc_busy_idle", 32'(acc_busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        busy_proc = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // result monitor
    always @(negedge clk) begin
        if (frame_done && !result_valid)
            chk("frame_done_alone", 32'(frame_done), 32'd0);
        if (result_valid) begin
            res_cnt++;
            if (frame_done) fd_cnt++;
            if (q_sum.size() == 0) begin
                chk("unexpected_result", 32'(result_valid), 32'd0);
            end else begin
                chk("result_data", 32'(result_data), 32'(q_sum[0]));
                chk("result_dir", 32'(result_dir), 32'(q_dir[0]));
                chk("result_cycle", cyc, q_cyc[0]);
                chk("frame_done", 32'(frame_done),
                    32'(q_dir[0] == 2'd3));
                void'(q_sum.pop_front());
                void'(q_dir.pop_front());
                void'(q_cyc.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        busy_proc = 1'b0;
        dir = 2'd0;
        dir_counter = 6'd0;
        a_data = 0;
        w_data = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_result_data", 32'(result_data), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_dir", 32'(result_dir), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_acc_busy", 32'(acc_busy), 32'd0);

        // directed and extreme frames, then random frames
        for (int m = 0; m < 8; m++) begin
            fill(m);
            res_cnt = 0;
            fd_cnt  = 0;
            run_frame();
            drain();
            chk("frame_results", res_cnt, 4);
            chk("frame_done_cnt", fd_cnt, 1);
            chk("seq_err_clean", 32'(seq_err), 32'd0);
        end

        // reset in the middle of pass 1
        fill(0);
        for (int c = 0; c < 36; c++) step(1'b1, 2'd0, 6'(c));
        for (int c = 0; c <= 20; c++) step(1'b1, 2'd1, 6'(c));
        reset = 1'b1;
        step(1'b0, 2'd0, 6'd0);
        reset = 1'b0;
        chk("midrst_result_valid", 32'(result_valid), 32'd0);
        chk("midrst_result_data", 32'(result_data), 32'd0);
        chk("midrst_acc_busy", 32'(acc_busy), 32'd0);
        chk("midrst_pending", q_sum.size(), 0);
        fill(7);
        run_frame();
        drain();
        chk("midrst_seq_err", 32'(seq_err), 32'd0);

        // pass abandoned after term 10, then restarted
        fill(0);
        for (int c = 0; c <= 10; c++) step(1'b1, 2'd0, 6'(c));
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 6'd0);
        chk("abandon_no_err_yet", 32'(seq_err), 32'd0);
        for (int c = 0; c < 36; c++) step(1'b1, 2'd0, 6'(c));
        drain();
        chk("abandon_seq_err", 32'(seq_err), 32'd1);
        do_reset();
        chk("seq_err_cleared", 32'(seq_err), 32'd0);

        // two frames separated by one idle cycle
        fill(6);
        res_cnt = 0;
        fd_cnt  = 0;
        run_frame();
        step(1'b0, 2'd0, 6'd0);
        run_frame();
        drain();
        chk("two_frame_results", res_cnt, 8);
        chk("two_frame_done", fd_cnt, 2);
        chk("two_frame_seq_err", 32'(seq_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
